mac_result_collector: RTL and testbench
=======================================

Name: mac_result_collector

Overview:
- HWPE-Stream sink for the MAC engine's d result stream; the consuming end of that interface.
- Takes wide signed results, clips to DOUT_WIDTH (optional saturation) and buffers them in a 2-entry FIFO.
- Streams results to a 32b output stream toward the streamer and counts them against a programmed total.
- Raises done once the last result has left the block.

Parameters:
DIN_WIDTH, 64, width of d_i.data (signed).
DOUT_WIDTH, 32, width of r_o.data (signed).
CNT_WIDTH, 16, width of the result counter and of ctrl_i.nb_results.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
test_mode_i  in  1  unused, kept for uniformity
d_i  hwpe_stream_intf_stream.sink  DIN_WIDTH  results from the engine
r_o  hwpe_stream_intf_stream.source  DOUT_WIDTH  clipped results toward the streamer
ctrl_i  in  ctrl_collector_t  fields: clear, enable, start, saturate, nb_results[CNT_WIDTH-1:0]
flags_o  out  flags_collector_t  fields: state, cnt_in, cnt_out, ovf (sticky), done

Behaviour:
Reset:
- Reset (rst_ni=0) is asynchronous; ctrl_i.clear is a synchronous equivalent of it.
- Both set: FIFO empty, counters 0, ovf=0, done=0, FSM=IDLE, d_i.ready=0, r_o.valid=0.
- r_o.strb is always '1.
- Reset or clear mid-transfer drops buffered data; no handshake completes in that cycle.

enable:
- ctrl_i.enable=0 freezes all registers.
- d_i.ready and r_o.valid are forced to 0 while enable=0.

FSM states (flags_o.state 2b):
- IDLE: ready=0. On start, go to RUN. If nb_results==0, go directly to DONE.
- RUN: d_i.ready = ~fifo_full & (cnt_in<nb_results). cnt_in increments on each d_i handshake. When cnt_in reaches nb_results, go to DRAIN.
- DRAIN: d_i.ready=0. When cnt_out==nb_results and the FIFO is empty, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Counters hold their values until the next start or clear.

Datapath:
- Input handshake: d_i.valid & d_i.ready. Output handshake: r_o.valid & r_o.ready.
- saturate=1: clip values above 2^(DOUT_WIDTH-1)-1 to that maximum, and values below -2^(DOUT_WIDTH-1) to that minimum. The clip is applied before the FIFO write.
- saturate=0: keep the low DOUT_WIDTH bits (wrap).
- ovf is sticky; it is set by any accepted input that does not fit in DOUT_WIDTH, in either saturate mode.

FIFO:
- 2 entries, so there is no combinational path from r_o.ready to d_i.ready.
- Write on input handshake, read on output handshake. Simultaneous read and write at occupancy 1 or 2 leaves occupancy unchanged.
- Write when full is impossible (ready=0). Read when empty is impossible (valid=0).
- r_o.valid = ~fifo_empty & enable.
- Latency from d_i handshake to r_o.valid is 1 cycle.

Stream rules:
- r_o data holds stable while valid & ~ready.
- valid never falls without a handshake, except on clear or reset.
- cnt_out increments on each r_o handshake.

Optional Feature:
MAC_COLLECTOR_STATS_EN
- Defined: adds flags_o.nb_sat[CNT_WIDTH-1:0], the number of accepted inputs that were clipped (saturate=1 only). It saturates at all-ones and is zeroed by reset, clear and start.
- Undefined: the field is tied to 0, and no counter logic exists.

Decomposition:
- mac_package gets ctrl_collector_t, flags_collector_t, and the collector_state_t enum (IDLE, RUN, DRAIN, DONE).
- mac_package also gets COLLECTOR_FIFO_DEPTH=2.
- One sub-module: mac_collector_clip, a combinational clip plus overflow detect, parameterised by DIN_WIDTH/DOUT_WIDTH. FSM, counters and FIFO stay in the top.

Test Plan:
- nb_results=4, saturate=1, inputs {5, -7, 0x7FFFFFFF, -0x80000000}, r_o.ready=1 -> outputs identical, ovf=0, done pulses once after the 4th output, cnt_out=4.
- saturate=1, input 0x1_0000_0000 -> output 0x7FFFFFFF; input -0x1_0000_0001 -> output 0x80000000; ovf=1; with STATS_EN, nb_sat=2.
- saturate=0, input 0x1_2345_6789 -> output 0x23456789, ovf=1.
- r_o.ready=0 for 5 cycles with d_i always valid -> exactly 2 inputs accepted, then d_i.ready=0. r_o data stays stable. After ready rises, order is preserved and no data is lost.
- nb_results=3 with the source offering 5 valid items -> only 3 handshakes; d_i.ready=0 in DRAIN and DONE.
- clear asserted in RUN with 2 items buffered -> next cycle r_o.valid=0, counters 0, state IDLE. Also nb_results=0 with start -> done on the next cycle with no handshakes.

Source files
------------

// File: rtl/mac_package.sv
// mac_package: shared types and constants for the MAC result collector.
//   collector_state_t  : collector FSM encoding (IDLE, RUN, DRAIN, DONE)
//   ctrl_collector_t   : clear, enable, start, saturate, nb_results
//   flags_collector_t  : state, cnt_in, cnt_out, ovf (sticky), done, nb_sat
// nb_sat is only counted when MAC_COLLECTOR_STATS_EN is defined; otherwise it reads 0.
package mac_package;

  localparam int unsigned COLLECTOR_FIFO_DEPTH = 2;
  localparam int unsigned COLLECTOR_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } collector_state_t;

  typedef struct packed {
    logic                           clear;
    logic                           enable;
    logic                           start;
    logic                           saturate;
    logic [COLLECTOR_CNT_WIDTH-1:0] nb_results;
  } ctrl_collector_t;

  typedef struct packed {
    collector_state_t               state;
    logic [COLLECTOR_CNT_WIDTH-1:0] cnt_in;
    logic [COLLECTOR_CNT_WIDTH-1:0] cnt_out;
    logic                           ovf;
    logic                           done;
    logic [COLLECTOR_CNT_WIDTH-1:0] nb_sat;
  } flags_collector_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready stream bundle.
//   valid, ready, data[DATA_WIDTH-1:0], strb[DATA_WIDTH/8-1:0]
//   modport source drives valid/data/strb, modport sink drives ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/mac_collector_clip.sv
// mac_collector_clip: combinational narrowing of a signed result.
//   din_i      : signed input, DIN_WIDTH bits (DIN_WIDTH > DOUT_WIDTH)
//   saturate_i : 1 = clamp to signed DOUT_WIDTH range, 0 = keep low bits
//   dout_o     : narrowed result
//   ovf_o      : input does not fit in DOUT_WIDTH (either mode)
//   sat_o      : input was clamped (ovf_o & saturate_i)
module mac_collector_clip #(
  parameter int unsigned DIN_WIDTH  = 64,
  parameter int unsigned DOUT_WIDTH = 32
) (
  input  logic [DIN_WIDTH-1:0]  din_i,
  input  logic                  saturate_i,
  output logic [DOUT_WIDTH-1:0] dout_o,
  output logic                  ovf_o,
  output logic                  sat_o
);

  // A value fits when every bit from the output sign bit upward equals the sign.
  logic [DIN_WIDTH-DOUT_WIDTH:0] hi;
  assign hi    = din_i[DIN_WIDTH-1:DOUT_WIDTH-1];
  assign ovf_o = ~((&hi) | ~(|hi));
  assign sat_o = ovf_o & saturate_i;

  always_comb begin
    dout_o = din_i[DOUT_WIDTH-1:0];
    if (sat_o)
      dout_o = din_i[DIN_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/mac_result_collector.sv
// mac_result_collector: sink for the MAC engine result stream.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   test_mode_i   : unused
//   d_i           : wide signed results from the engine (sink)
//   r_o           : clipped results toward the streamer (source), strb all ones
//   ctrl_i        : clear (sync reset), enable (freeze when 0), start, saturate, nb_results
//   flags_o       : state, cnt_in, cnt_out, sticky ovf, one-cycle done, nb_sat
// Results are narrowed, buffered in a 2-entry FIFO and counted against nb_results;
// done fires once the last result has been taken by the consumer.
// Optional: MAC_COLLECTOR_STATS_EN adds the nb_sat counter of clamped inputs.
// CNT_WIDTH must equal mac_package::COLLECTOR_CNT_WIDTH (struct field width).
module mac_result_collector
  import mac_package::*;
#(
  parameter int unsigned DIN_WIDTH  = 64,
  parameter int unsigned DOUT_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = COLLECTOR_CNT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             test_mode_i,
  hwpe_stream_intf_stream.sink   d_i,
  hwpe_stream_intf_stream.source r_o,
  input  ctrl_collector_t  ctrl_i,
  output flags_collector_t flags_o
);

  collector_state_t      state_q;
  logic [CNT_WIDTH-1:0]  cnt_in_q, cnt_out_q, nb_sat;
  logic                  ovf_q;

  logic [DOUT_WIDTH-1:0] mem_q [COLLECTOR_FIFO_DEPTH];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;
  logic                  fifo_full, fifo_empty;

  logic [DOUT_WIDTH-1:0] clip_data;
  logic                  clip_ovf, clip_sat;
  logic                  live, in_hs, out_hs;
  logic                  unused_in;

  assign unused_in = ^{test_mode_i, d_i.strb};

  mac_collector_clip #(
    .DIN_WIDTH  (DIN_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) i_clip (
    .din_i      (d_i.data),
    .saturate_i (ctrl_i.saturate),
    .dout_o     (clip_data),
    .ovf_o      (clip_ovf),
    .sat_o      (clip_sat)
  );

  assign fifo_full  = (occ_q == 2'(COLLECTOR_FIFO_DEPTH));
  assign fifo_empty = (occ_q == 2'd0);

  // Handshakes are suppressed in a clear cycle as well as while disabled.
  assign live      = ctrl_i.enable & ~ctrl_i.clear;
  // ready depends only on registered FIFO state, never on r_o.ready.
  assign d_i.ready = live & (state_q == RUN) & ~fifo_full & (cnt_in_q < ctrl_i.nb_results);
  assign r_o.valid = live & ~fifo_empty;
  assign r_o.data  = mem_q[rd_ptr_q];
  assign r_o.strb  = '1;

  assign in_hs  = d_i.valid & d_i.ready;
  assign out_hs = r_o.valid & r_o.ready;

  // 2-entry FIFO
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (ctrl_i.clear) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else if (ctrl_i.enable) begin
      if (in_hs) begin
        mem_q[wr_ptr_q] <= clip_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (out_hs) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, in_hs} - {1'b0, out_hs};
    end
  end

  // FSM, counters and sticky overflow
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
      ovf_q     <= 1'b0;
    end else if (ctrl_i.clear) begin
      state_q   <= IDLE;
      cnt_in_q  <= '0;
      cnt_out_q <= '0;
      ovf_q     <= 1'b0;
    end else if (ctrl_i.enable) begin
      if (in_hs)            cnt_in_q  <= cnt_in_q + CNT_WIDTH'(1);
      if (out_hs)           cnt_out_q <= cnt_out_q + CNT_WIDTH'(1);
      if (in_hs & clip_ovf) ovf_q     <= 1'b1;
      case (state_q)
        IDLE: if (ctrl_i.start) begin
          cnt_in_q  <= '0;
          cnt_out_q <= '0;
          state_q   <= (ctrl_i.nb_results == '0) ? DONE : RUN;
        end
        RUN: if ((in_hs && (cnt_in_q + CNT_WIDTH'(1) == ctrl_i.nb_results)) ||
                 (cnt_in_q >= ctrl_i.nb_results))
          state_q <= DRAIN;
        DRAIN: if ((cnt_out_q == ctrl_i.nb_results) && fifo_empty)
          state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MAC_COLLECTOR_STATS_EN
  logic [CNT_WIDTH-1:0] nb_sat_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      nb_sat_q <= '0;
    else if (ctrl_i.clear)
      nb_sat_q <= '0;
    else if (ctrl_i.enable) begin
      if ((state_q == IDLE) && ctrl_i.start)
        nb_sat_q <= '0;
      else if (in_hs && clip_sat && !(&nb_sat_q))
        nb_sat_q <= nb_sat_q + CNT_WIDTH'(1);
    end
  end
  assign nb_sat = nb_sat_q;
`else
  logic unused_sat;
  assign unused_sat = clip_sat;
  assign nb_sat     = '0;
`endif

  always_comb begin
    flags_o         = '0;
    flags_o.state   = state_q;
    flags_o.cnt_in  = cnt_in_q;
    flags_o.cnt_out = cnt_out_q;
    flags_o.ovf     = ovf_q;
    flags_o.done    = (state_q == DONE);
    flags_o.nb_sat  = nb_sat;
  end

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector.
module tb_mac_result_collector;
  import mac_package::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_collector_t  ctrl;
  flags_collector_t flags;

  hwpe_stream_intf_stream #(.DATA_WIDTH(64)) d_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) r_if ();

  mac_result_collector #(
    .DIN_WIDTH(64), .DOUT_WIDTH(32), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0),
    .d_i(d_if), .r_o(r_if), .ctrl_i(ctrl), .flags_o(flags)
  );

  int n_vec = 0, n_err = 0;
  int n_in, n_out, n_done;
  logic [63:0] in_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] held;
  bit          held_v;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic prep();
    n_in = 0; n_out = 0; n_done = 0; held_v = 0;
    in_q.delete(); exp_q.delete();
  endtask

  task automatic do_clear();
    ctrl.clear = 1'b1; tick(); ctrl.clear = 1'b0;
  endtask

  task automatic go(input logic [15:0] nb, input logic sat);
    ctrl.nb_results = nb; ctrl.saturate = sat; ctrl.start = 1'b1;
    tick(); ctrl.start = 1'b0;
  endtask

  // Offer in_q, accept outputs after `stall` cycles, check order/stability/ready.
  task automatic stream(input int cycles, input int stall);
    for (int c = 0; c < cycles; c++) begin
      d_if.valid = (in_q.size() > 0);
      d_if.data  = (in_q.size() > 0) ? in_q[0] : 64'h0;
      r_if.ready = (c >= stall);
      #1;
      if (flags.done) n_done++;
      if (flags.state == DRAIN || flags.state == DONE)
        chk("ready_in_drain_done", 64'(d_if.ready), 64'd0);
      if (d_if.valid && d_if.ready) begin
        n_in++;
        void'(in_q.pop_front());
      end
      if (r_if.valid && !r_if.ready) begin
        if (held_v) chk("data_stable", 64'(r_if.data), 64'(held));
        held = r_if.data; held_v = 1;
      end
      if (r_if.valid && r_if.ready) begin
        n_out++; held_v = 0;
        if (exp_q.size() > 0) chk("out_data", 64'(r_if.data), 64'(exp_q.pop_front()));
      end
      tick();
    end
    d_if.valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_sat;
    ctrl = '0; ctrl.enable = 1'b1;
    d_if.valid = 1'b0; d_if.data = '0; d_if.strb = '1;
    r_if.ready = 1'b0;

    // reset
    #12;
    chk("rst_state", 64'(flags.state), 64'(IDLE));
    chk("rst_rvalid", 64'(r_if.valid), 64'd0);
    chk("rst_dready", 64'(d_if.ready), 64'd0);
    chk("rst_cnt_in", 64'(flags.cnt_in), 64'd0);
    chk("rst_ovf", 64'(flags.ovf), 64'd0);
    chk("strb", 64'(r_if.strb), 64'hF);
    rst_n = 1'b1;
    tick();
    chk("post_rst_done", 64'(flags.done), 64'd0);
    chk("post_rst_dready", 64'(d_if.ready), 64'd0);

    // in-range values pass through untouched
    prep();
    in_q  = '{64'd5, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_7FFF_FFFF, 64'hFFFF_FFFF_8000_0000};
    exp_q = '{32'd5, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'h8000_0000};
    go(16'd4, 1'b1);
    chk("t1_state_run", 64'(flags.state), 64'(RUN));
    stream(15, 0);
    chk("t1_n_out", 64'(n_out), 64'd4);
    chk("t1_done_once", 64'(n_done), 64'd1);
    chk("t1_cnt_out", 64'(flags.cnt_out), 64'd4);
    chk("t1_ovf", 64'(flags.ovf), 64'd0);
    chk("t1_nb_sat", 64'(flags.nb_sat), 64'd0);
    chk("t1_idle", 64'(flags.state), 64'(IDLE));

    // saturation in both directions
    prep(); do_clear();
    in_q  = '{64'h0000_0001_0000_0000, 64'hFFFF_FFFE_FFFF_FFFF};
    exp_q = '{32'h7FFF_FFFF, 32'h8000_0000};
    go(16'd2, 1'b1);
    stream(10, 0);
    chk("t2_n_out", 64'(n_out), 64'd2);
    chk("t2_ovf", 64'(flags.ovf), 64'd1);
`ifdef MAC_COLLECTOR_STATS_EN
    exp_sat = 64'd2;
`else
    exp_sat = 64'd0;
`endif
    chk("t2_nb_sat", 64'(flags.nb_sat), exp_sat);

    // wrap mode
    prep(); do_clear();
    chk("t3_ovf_cleared", 64'(flags.ovf), 64'd0);
    in_q  = '{64'h0000_0001_2345_6789};
    exp_q = '{32'h2345_6789};
    go(16'd1, 1'b0);
    stream(8, 0);
    chk("t3_n_out", 64'(n_out), 64'd1);
    chk("t3_ovf", 64'(flags.ovf), 64'd1);
    chk("t3_nb_sat", 64'(flags.nb_sat), 64'd0);

    // backpressure: FIFO fills at two, then enable freeze, then drain in order
    prep(); do_clear();
    in_q  = '{64'd1, 64'd2, 64'd3, 64'd4};
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    go(16'd4, 1'b1);
    stream(5, 5);
    chk("t4_accepted", 64'(n_in), 64'd2);
    chk("t4_no_out", 64'(n_out), 64'd0);
    d_if.valid = 1'b1; d_if.data = 64'd3; #1;
    chk("t4_dready_full", 64'(d_if.ready), 64'd0);
    chk("t4_rvalid_full", 64'(r_if.valid), 64'd1);
    ctrl.enable = 1'b0; #1;
    chk("t4_rvalid_disabled", 64'(r_if.valid), 64'd0);
    tick();
    chk("t4_frozen_cnt", 64'(flags.cnt_in), 64'd2);
    chk("t4_frozen_state", 64'(flags.state), 64'(RUN));
    ctrl.enable = 1'b1; d_if.valid = 1'b0;
    stream(20, 0);
    chk("t4_n_in", 64'(n_in), 64'd4);
    chk("t4_n_out", 64'(n_out), 64'd4);
    chk("t4_exp_left", 64'(exp_q.size()), 64'd0);
    chk("t4_done", 64'(n_done), 64'd1);

    // only nb_results items taken from an eager source
    prep(); do_clear();
    in_q  = '{64'd10, 64'd11, 64'd12, 64'd13, 64'd14};
    exp_q = '{32'd10, 32'd11, 32'd12};
    go(16'd3, 1'b1);
    stream(15, 0);
    chk("t5_n_in", 64'(n_in), 64'd3);
    chk("t5_leftover", 64'(in_q.size()), 64'd2);
    chk("t5_n_out", 64'(n_out), 64'd3);
    chk("t5_cnt_in", 64'(flags.cnt_in), 64'd3);
    chk("t5_done", 64'(n_done), 64'd1);

    // clear with two items buffered
    prep(); do_clear();
    in_q = '{64'hA, 64'hB, 64'hC, 64'hD};
    go(16'd4, 1'b1);
    stream(3, 3);
    chk("t6_buffered", 64'(n_in), 64'd2);
    d_if.valid = 1'b1; d_if.data = 64'hC; r_if.ready = 1'b1;
    ctrl.clear = 1'b1; #1;
    chk("t6_clr_rvalid", 64'(r_if.valid), 64'd0);
    chk("t6_clr_dready", 64'(d_if.ready), 64'd0);
    tick(); ctrl.clear = 1'b0; d_if.valid = 1'b0; #1;
    chk("t6_rvalid", 64'(r_if.valid), 64'd0);
    chk("t6_cnt_in", 64'(flags.cnt_in), 64'd0);
    chk("t6_cnt_out", 64'(flags.cnt_out), 64'd0);
    chk("t6_state", 64'(flags.state), 64'(IDLE));

    // nb_results = 0 goes straight to DONE
    go(16'd0, 1'b1); #1;
    chk("t7_done", 64'(flags.done), 64'd1);
    chk("t7_cnt_in", 64'(flags.cnt_in), 64'd0);
    tick();
    chk("t7_done_drop", 64'(flags.done), 64'd0);
    chk("t7_idle", 64'(flags.state), 64'(IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
